mc_controller_hs: RTL

Next-generation multicycle MIPS control unit, replacing the fixed-latency controller beside the datapath. Drives every datapath select and enable signal from a 12-state FSM and computes pc_en internally. Stalls in memory states on a ready handshake, so variable-latency memory can be used. Also counts retired instructions and flags illegal instructions and memory timeouts.

---
 rtl/mc_controller_hs_if.sv | 35 +++
 rtl/mc_controller_hs.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller_hs_if.sv
// Datapath-side bundle for the multicycle MIPS controller: decode inputs,
// memory handshake, and every select/enable driven back into the datapath.
interface mc_controller_hs_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       mem_to_reg;
    logic       reg_dst;
    logic       iord;
    logic       alu_src_a;
    logic       ir_write;
    logic       mem_write;
    logic       pc_write;
    logic       branch;
    logic       reg_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;

    // The controller is the master: it consumes decode/handshake inputs and drives controls.
    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_to_reg, reg_dst, iord, alu_src_a, ir_write, mem_write,
               pc_write, branch, reg_write, pc_en, pc_src, alu_src_b, alu_control
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_to_reg, reg_dst, iord, alu_src_a, ir_write, mem_write,
               pc_write, branch, reg_write, pc_en, pc_src, alu_src_b, alu_control
    );
endinterface

// File: rtl/mc_controller_hs.sv
// Multicycle MIPS control FSM with ready-handshake stalls, retire counter and
// sticky illegal/timeout flags. Define MC_BNE_EN to add the bne instruction.
module mc_controller_hs #(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    mc_controller_hs_if.master   bus,
    output logic [3:0]           state,
    output logic [CNT_W-1:0]     instr_count,
    output logic                 illegal,
    output logic                 mem_timeout
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BEQ    = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

`ifdef MC_BNE_EN
    localparam logic [3:0] S_BNE    = 4'd12;
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam bit                WAIT_ON  = (WAIT_MAX != 0);
    localparam int                WC_W     = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [WC_W-1:0]   WAIT_LIM = WC_W'(WAIT_MAX);

    logic [3:0]       state_reg, state_next;
    logic [WC_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0] count_reg;
    logic             illegal_reg, timeout_reg;

    logic             in_wait, timeout_hit, retire, illegal_set;
    logic             funct_ok;
    logic [2:0]       alu_fn;

    // R-type function decode; unknown functs still execute as add.
    always_comb begin
        funct_ok = 1'b1;
        alu_fn   = 3'b010;
        case (bus.funct)
            6'b100000: alu_fn = 3'b010;
            6'b100010: alu_fn = 3'b110;
            6'b100100: alu_fn = 3'b000;
            6'b100101: alu_fn = 3'b001;
            6'b101010: alu_fn = 3'b111;
            default:   funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        in_wait       = 1'b0;
        retire        = 1'b0;
        illegal_set   = 1'b0;
        timeout_hit   = 1'b0;
        wait_cnt_next = '0;
        case (state_reg)
            S_FETCH: begin
                in_wait = 1'b1;
                if (bus.mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
`ifdef MC_BNE_EN
                    OP_BNE:       state_next = S_BNE;
`endif
                    default: begin
                        state_next  = S_FETCH;
                        illegal_set = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                in_wait = 1'b1;
                if (bus.mem_ready) state_next = S_MEMWB;
            end
            S_MEMWR: begin
                in_wait = 1'b1;
                if (bus.mem_ready) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end
            end
            S_EXEC: begin
                state_next  = S_ALUWB;
                illegal_set = ~funct_ok;
            end
            S_ADDIEX: state_next = S_ADDIWB;
`ifdef MC_BNE_EN
            S_BNE,
`endif
            S_MEMWB, S_ALUWB, S_BEQ, S_ADDIWB, S_JUMP: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase

        // A ready in the limit cycle wins; only a still-stalled access is aborted.
        if (WAIT_ON && in_wait && !bus.mem_ready && (wait_cnt_reg == WAIT_LIM)) begin
            timeout_hit = 1'b1;
            state_next  = S_FETCH;
            retire      = 1'b0;
        end
        if (WAIT_ON && in_wait && !bus.mem_ready && !timeout_hit)
            wait_cnt_next = wait_cnt_reg + WC_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= '0;
            count_reg    <= '0;
            illegal_reg  <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (retire)      count_reg   <= count_reg + CNT_W'(1);
            if (illegal_set) illegal_reg <= 1'b1;
            if (timeout_hit) timeout_reg <= 1'b1;
        end
    end

`ifdef MC_BNE_EN
    logic branch_ne;
`endif

    // Moore decode of datapath controls; FETCH's write strobes follow the handshake.
    always_comb begin
        bus.mem_to_reg  = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.iord        = 1'b0;
        bus.alu_src_a   = 1'b0;
        bus.ir_write    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.pc_write    = 1'b0;
        bus.branch      = 1'b0;
        bus.reg_write   = 1'b0;
        bus.pc_src      = 2'b00;
        bus.alu_src_b   = 2'b00;
        bus.alu_control = 3'b010;
`ifdef MC_BNE_EN
        branch_ne       = 1'b0;
`endif
        case (state_reg)
            S_FETCH: begin
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE: bus.alu_src_b = 2'b11;
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_MEMRD: bus.iord = 1'b1;
            S_MEMWB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                bus.iord      = 1'b1;
                bus.mem_write = 1'b1;
            end
            S_EXEC: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = alu_fn;
            end
            S_ALUWB: begin
                bus.reg_dst   = 1'b1;
                bus.reg_write = 1'b1;
            end
            S_BEQ: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = 3'b110;
                bus.pc_src      = 2'b01;
                bus.branch      = 1'b1;
            end
`ifdef MC_BNE_EN
            S_BNE: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = 3'b110;
                bus.pc_src      = 2'b01;
                branch_ne       = 1'b1;
            end
`endif
            S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_ADDIWB: bus.reg_write = 1'b1;
            S_JUMP: begin
                bus.pc_src   = 2'b10;
                bus.pc_write = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef MC_BNE_EN
    assign bus.pc_en = bus.pc_write | (bus.branch & bus.zero) | (branch_ne & ~bus.zero);
`else
    assign bus.pc_en = bus.pc_write | (bus.branch & bus.zero);
`endif

    assign state       = state_reg;
    assign instr_count = count_reg;
    assign illegal     = illegal_reg;
    assign mem_timeout = timeout_reg;

endmodule
